// File: rtl/imem_responder.sv
// imem_responder
//
// Instruction-memory responder for the fetch stage. Accepts one word-addressed
// fetch per cycle and returns the instruction word LATENCY cycles later with a
// one-cycle valid strobe. Misaligned or out-of-range fetches return a NOP with
// imem_fault set. A flush drops every in-flight response plus the request
// presented in the same cycle. A side load port writes the array.
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-high reset (pipeline and outputs only)
//   imem_addr   byte address of the requested instruction
//   imem_req    request strobe, sampled every edge
//   imem_rdata  returned instruction word (holds last value when not valid)
//   imem_valid  response strobe, one cycle per accepted request
//   imem_fault  response was misaligned / out of range (0 when not valid)
//   flush       drop all in-flight responses and the current request
//   load_we     array write enable
//   load_addr   word index to write
//   load_data   word to write
//
// DEPTH_WORDS must be a power of two between 2 and 2^29; LATENCY is 1..4.

module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1,
   localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   imem_addr,
   input  logic          imem_req,
   output logic [31:0]   imem_rdata,
   output logic          imem_valid,
   output logic          imem_fault,
   input  logic          flush,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] mem [DEPTH_WORDS];

   // Stage 0 is the synchronous array read; later stages are pure delay.
   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] fault_q;
   logic [31:0]        data_q [LATENCY];

   logic [AW-1:0] req_idx;
   logic          req_misaligned;
   logic          req_out_of_range;
   logic          req_fault;
   logic          accept;
   logic [31:0]   rd_word;

   always_comb begin
      req_idx          = imem_addr[AW+1:2];
      req_misaligned   = |imem_addr[1:0];
      req_out_of_range = |imem_addr[31:AW+2];
      req_fault        = req_misaligned | req_out_of_range;
      accept           = imem_req & ~flush;
      rd_word          = req_fault ? NOP : mem[req_idx];
   end

   // Array has no reset. The pipeline samples mem with the pre-write value,
   // which gives read-first behaviour on a same-index load.
   always_ff @(posedge clk) begin
      if (load_we) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q   <= '0;
         fault_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= accept;
         if (accept) begin
            data_q[0]  <= rd_word;
            fault_q[0] <= req_fault;
         end
         // Data only moves alongside a surviving valid, so the last stage keeps
         // the most recently delivered word while idle or after a flush.
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1] & ~flush;
            if (vld_q[i-1] && !flush) begin
               data_q[i]  <= data_q[i-1];
               fault_q[i] <= fault_q[i-1];
            end
         end
      end
   end

   always_comb begin
      imem_valid = vld_q[LATENCY-1];
      imem_fault = vld_q[LATENCY-1] & fault_q[LATENCY-1];
      imem_rdata = data_q[LATENCY-1];
   end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   imem_addr;
   logic          imem_req;
   logic          flush;
   logic          load_we;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;

   logic [31:0] rdata1, rdata3;
   logic        valid1, valid3, fault1, fault3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_rdata(rdata1), .imem_valid(valid1), .imem_fault(fault1),
      .flush(flush), .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
   );

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_rdata(rdata3), .imem_valid(valid3), .imem_fault(fault3),
      .flush(flush), .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
   );

   // Reference model: memory image plus a list of scheduled responses, each
   // tagged with the edge count after which it must be visible.
   typedef struct {
      int          due;
      logic [31:0] data;
      logic        fault;
   } resp_t;

   logic [31:0] mm [DEPTH];
   resp_t       q1 [$];
   resp_t       q3 [$];
   logic [31:0] last1, last3;
   int          n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q3.delete();
      last1 = '0;
      last3 = '0;
   endtask

   task automatic step();
      resp_t       r;
      logic        ev;
      logic        ef;
      logic [31:0] ed;
      @(posedge clk);
      n++;
      if (flush) begin
         q1.delete();
         q3.delete();
      end
      if (imem_req && !flush) begin
         r.fault = (imem_addr % 4 != 0) || (imem_addr >= DEPTH * 4);
         r.data  = r.fault ? 32'h0000_0013 : mm[imem_addr / 4];
         r.due   = n;
         q1.push_back(r);
         r.due   = n + 2;
         q3.push_back(r);
      end
      if (load_we) mm[load_addr] = load_data;
      #1;
      ev = 1'b0; ef = 1'b0; ed = last1;
      if (q1.size() > 0 && q1[0].due == n) begin
         ev = 1'b1; ef = q1[0].fault; ed = q1[0].data; last1 = ed;
         void'(q1.pop_front());
      end
      chk("m1_valid", valid1, ev);
      chk("m1_fault", fault1, ef);
      chk("m1_rdata", rdata1, ed);
      ev = 1'b0; ef = 1'b0; ed = last3;
      if (q3.size() > 0 && q3[0].due == n) begin
         ev = 1'b1; ef = q3[0].fault; ed = q3[0].data; last3 = ed;
         void'(q3.pop_front());
      end
      chk("m3_valid", valid3, ev);
      chk("m3_fault", fault3, ef);
      chk("m3_rdata", rdata3, ed);
   endtask

   task automatic drive(input logic req, input logic [31:0] addr, input logic fl,
                        input logic we, input logic [AW-1:0] la, input logic [31:0] ld);
      imem_req  = req;
      imem_addr = addr;
      flush     = fl;
      load_we   = we;
      load_addr = la;
      load_data = ld;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
         step();
      end
   endtask

   typedef struct {
      logic          req;
      logic [31:0]   addr;
      logic          fl;
      logic          we;
      logic [AW-1:0] la;
      logic [31:0]   ld;
      logic          ev;
      logic          ef;
      logic [31:0]   ed;
   } vec_t;

   vec_t tbl [17];

   initial begin
      logic [7:0]  pat8;
      logic [8:0]  pat9;
      logic [3:0]  pat4;
      logic [31:0] flush_data;
      int          r;
      int          k;

      // Expected outputs are for the LATENCY=1 instance.
      tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b1, 6'd0,  32'h0000_0093, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 6'd1,  32'h0010_0113, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 6'd2,  32'h0020_0193, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 6'd3,  32'h0030_0213, 1'b0, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 32'd0,        1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 32'h0000_0093};
      tbl[5]  = '{1'b1, 32'd4,        1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 32'h0010_0113};
      tbl[6]  = '{1'b1, 32'd8,        1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 32'h0020_0193};
      tbl[7]  = '{1'b1, 32'd12,       1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 32'h0030_0213};
      tbl[8]  = '{1'b1, 32'd6,        1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b1, 32'h0000_0013};
      tbl[9]  = '{1'b1, DEPTH * 4,    1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b1, 32'h0000_0013};
      tbl[10] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 32'h0000_0013};
      tbl[11] = '{1'b1, 32'd2,        1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b1, 32'h0000_0013};
      tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 6'd63, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0013};
      tbl[13] = '{1'b1, (DEPTH - 1) * 4, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
      tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0,  32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF};
      tbl[15] = '{1'b1, 32'd0,        1'b1, 1'b0, 6'd0,  32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF};
      tbl[16] = '{1'b1, 32'd4,        1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 32'h0010_0113};

      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
      n = 0;
      model_reset();
      #12;
      chk("rst_valid1", valid1, 1'b0);
      chk("rst_fault1", fault1, 1'b0);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_valid3", valid3, 1'b0);
      chk("rst_rdata3", rdata3, 32'h0);
      rst = 1'b0;

      // Fill the whole array so every in-range read has a known value.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1, AW'(i), $urandom);
         step();
      end

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].req, tbl[i].addr, tbl[i].fl, tbl[i].we, tbl[i].la, tbl[i].ld);
         step();
         chk($sformatf("tbl%0d_valid", i), valid1, tbl[i].ev);
         chk($sformatf("tbl%0d_fault", i), fault1, tbl[i].ef);
         chk($sformatf("tbl%0d_rdata", i), rdata1, tbl[i].ed);
      end

      // Single request on the LATENCY=3 instance: valid only after the third edge.
      idle(4);
      pat4 = '0;
      drive(1'b1, 32'd4, 1'b0, 1'b0, '0, 32'h0);
      step();
      pat4[0] = valid3;
      for (int i = 1; i < 4; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
         step();
         pat4[i] = valid3;
         if (i == 2) chk("lat3_rdata", rdata3, mm[1]);
      end
      chk("lat3_pattern", 32'(pat4), 32'b0100);

      // Four-deep burst gives four contiguous valid cycles.
      idle(3);
      pat8 = '0;
      for (int i = 0; i < 8; i++) begin
         drive(i < 4, 32'(i * 4), 1'b0, 1'b0, '0, 32'h0);
         step();
         pat8[i] = valid3;
      end
      chk("burst3_pattern", 32'(pat8), 32'b0011_1100);

      // Flush on the LATENCY=3 instance. The addr-0 response has already
      // emerged by the flush edge; addr 4, 8 and the flush-cycle addr 12 vanish.
      idle(3);
      pat9 = '0;
      flush_data = '0;
      for (int i = 0; i < 9; i++) begin
         case (i)
            0: drive(1'b1, 32'd0,  1'b0, 1'b0, '0, 32'h0);
            1: drive(1'b1, 32'd4,  1'b0, 1'b0, '0, 32'h0);
            2: drive(1'b1, 32'd8,  1'b0, 1'b0, '0, 32'h0);
            3: drive(1'b1, 32'd12, 1'b1, 1'b0, '0, 32'h0);
            4: drive(1'b1, 32'd32, 1'b0, 1'b0, '0, 32'h0);
            default: drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
         endcase
         step();
         pat9[i] = valid3;
         if (i == 6) flush_data = rdata3;
      end
      chk("flush3_pattern", 32'(pat9), 32'b0_0100_0100);
      chk("flush3_rdata", flush_data, mm[8]);

      // Flush together with a load: the load still lands.
      drive(1'b0, 32'h0, 1'b1, 1'b1, 6'd9, 32'h1234_5678);
      step();
      drive(1'b1, 32'd36, 1'b0, 1'b0, '0, 32'h0);
      step();
      chk("flushload_rdata1", rdata1, 32'h1234_5678);

      // Read-first collision on the same index.
      drive(1'b0, 32'h0, 1'b0, 1'b1, 6'd5, 32'hAAAA_AAAA);
      step();
      drive(1'b1, 32'd20, 1'b0, 1'b1, 6'd5, 32'h5555_5555);
      step();
      chk("coll_old", rdata1, 32'hAAAA_AAAA);
      drive(1'b1, 32'd20, 1'b0, 1'b0, '0, 32'h0);
      step();
      chk("coll_new", rdata1, 32'h5555_5555);

      // Asynchronous reset with two responses pending in the LATENCY=3 instance.
      idle(3);
      drive(1'b1, 32'd0, 1'b0, 1'b0, '0, 32'h0);
      step();
      drive(1'b1, 32'd4, 1'b0, 1'b0, '0, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
      #3 rst = 1'b1;
      #1;
      chk("arst_valid1", valid1, 1'b0);
      chk("arst_rdata1", rdata1, 32'h0);
      chk("arst_valid3", valid3, 1'b0);
      chk("arst_fault3", fault3, 1'b0);
      chk("arst_rdata3", rdata3, 32'h0);
      model_reset();
      #1 rst = 1'b0;
      pat4 = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         pat4[i] = valid3;
      end
      chk("arst_stale3", 32'(pat4), 32'h0);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         r = $urandom_range(0, 99);
         k = $urandom_range(0, 9);
         if (k <= 5)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
         else if (k == 6)  a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         else if (k == 7)  a = $urandom | 32'h0000_0100;
         else if (k == 8)  a = (DEPTH - 1) * 4;
         else              a = DEPTH * 4;
         drive(r < 70, a, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
               AW'($urandom_range(0, DEPTH - 1)), $urandom);
         step();
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
